serial_adder_ctrl: RTL
======================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial front end for the full_adder cell.
//  - Accepts two WIDTH-bit operands over a valid/ready handshake.
//  - Feeds one bit pair per cycle, LSB first, into a single full_adder instance.
//  - Holds the carry in a flop between cycles.
//  - Collects the sum bits into a shift register and presents the result over a
//    valid/ready handshake.
//  - Trades latency for area against the parallel ripple-carry array.
// PARAMETERS
//  WIDTH   36   operand/result width in bits, >= 2
//  CNT_W   6    bit counter width, must satisfy 2**CNT_W >= WIDTH
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand set valid
//  in_ready   out  1      block can accept operands (IDLE state)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in
//  sub        in   1      subtract request (only present with SERIAL_SUB_EN)
//  out_valid  out  1      result valid (DONE state)
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result, LSB = bit 0
//  cout       out  1      carry-out of the MSB stage
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset: rst_n low -> state=IDLE, counter=0, carry flop=0, all shift regs=0.
//   Outputs under reset: sum=0, cout=0, out_valid=0, busy=0, in_ready=1.
//   Reset mid-RUN or mid-DONE aborts the operation; no partial result is ever
//   presented.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1.
//   - On in_valid&&in_ready: latch a and b into shift regs, carry<=cin,
//     counter<=0, go RUN.
//  RUN: each cycle, the full_adder gets (a_sh[0], b_sh[0], carry).
//   - sum_sh <= {s, sum_sh[WIDTH-1:1]}, carry <= co.
//   - a_sh and b_sh shift right by 1; counter++.
//   - When counter==WIDTH-1 the last bit is processed this cycle; go DONE.
//  DONE: out_valid=1; sum=sum_sh; cout=carry.
//   - sum and cout are held stable while out_ready=0.
//   - On out_ready: go IDLE.
//  Latency: operands accepted at edge k -> out_valid high after edge k+WIDTH.
//   RUN lasts exactly WIDTH cycles.
//  Throughput: one op per WIDTH+2 cycles minimum. in_ready is low from the
//   accept edge until the cycle after the output handshake. No overlap.
//  Arithmetic: {cout,sum} == a + b + cin, modulo 2**(WIDTH+1).
//   MSB overflow wraps: sum keeps the low WIDTH bits; cout holds bit WIDTH.
//  in_valid while busy: ignored. Operand inputs are sampled only on accept.
//  a, b, cin changes after accept have no effect.
//  in_ready and out_valid are decoded from state only; no combinational paths
//   from in_valid or out_ready.
// CONFIGURATION
//  SERIAL_SUB_EN defined: port sub exists and is sampled on accept.
//   - If sub=1: b_sh is loaded with ~b and carry with 1 (cin ignored).
//     Result {cout,sum} = a + ~b + 1, i.e. sum = a-b mod 2**WIDTH,
//     cout=1 means no borrow.
//   - If sub=0: add as normal.
//  SERIAL_SUB_EN undefined: port sub is absent; addition only; identical
//   timing in both builds.
// TESTING
//  1 a=0x000000001 b=0x000000001 cin=0
//    -> sum=0x000000002, cout=0; out_valid exactly 36 cycles after accept.
//  2 a=0xFFFFFFFFF b=0x000000001 cin=0 -> sum=0x000000000, cout=1 (wrap).
//    a=0xFFFFFFFFF b=0xFFFFFFFFF cin=1 -> sum=0xFFFFFFFFF, cout=1.
//  3 out_ready held 0 for 10 cycles in DONE
//    -> sum/cout/out_valid stable; in_ready=0.
//    New in_valid pulses ignored; accept resumes only the cycle after the
//    out_ready handshake.
//  4 rst_n pulsed low at RUN cycle 20 -> out_valid=0, sum=0, cout=0,
//    in_ready=1 immediately (async). A following op a=3 b=4 -> sum=7.
//  5 SERIAL_SUB_EN: sub=1 a=5 b=7 -> sum=0xFFFFFFFFE, cout=0;
//    sub=1 a=7 b=5 -> sum=0x000000002, cout=1.
//  6 1000 random a/b/cin with random in_valid/out_ready gaps
//    -> every result equals a+b+cin; no dropped or duplicated transactions.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - operand/result handshake bundle for serial_adder_ctrl
// Optional SERIAL_SUB_EN adds the sub request line.
interface serial_adder_ctrl_if #(parameter int WIDTH = 36);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

`ifdef SERIAL_SUB_EN
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, busy);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout, busy);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, busy);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, busy);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder, one full_adder cell reused LSB first
// Optional SERIAL_SUB_EN: adds a sub request that computes a - b via a + ~b + 1.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 36,
  parameter int CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Subtraction reuses the adder: invert B and force the carry-in.
  always_comb begin
    b_load = bus.b;
    c_load = bus.cin;
`ifdef SERIAL_SUB_EN
    if (bus.sub) begin
      b_load = ~bus.b;
      c_load = 1'b1;
    end
`endif
  end

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      carry       <= 1'b0;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh       <= bus.a;
            b_sh       <= b_load;
            carry      <= c_load;
            cnt        <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          carry  <= fa_co;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // The shift register and carry flop stay frozen in DONE, so they are the result.
  assign bus.sum       = sum_sh;
  assign bus.cout      = carry;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
endmodule
